// File: rtl/armleg_run_ctrl_if.sv
// rtl/armleg_run_ctrl_if.sv - control/status bundle between a run master and armleg_run_ctrl
//
// Purpose: groups the run-control inputs and the core-facing/status outputs.
// Signals:
//   start       begin a run (honoured in IDLE and HALT)
//   halt_req    stop the current run (honoured in RUN)
//   div_cfg     CH packed divide fields, channel i at [i*DIV_W +: DIV_W]
//   core_rst_n  active-low reset to the core
//   ce          per-channel clock enables
//   running     high while in RUN
//   done        high while in HALT
//   cycle_cnt   RUN cycles of the current/last run
//   halt_cause  bit0 = halt_req, bit1 = budget reached
interface armleg_run_ctrl_if #(
    parameter int CH    = 2,
    parameter int DIV_W = 8,
    parameter int CNT_W = 32
);
    logic                  start;
    logic                  halt_req;
    logic [CH*DIV_W-1:0]   div_cfg;
    logic                  core_rst_n;
    logic [CH-1:0]         ce;
    logic                  running;
    logic                  done;
    logic [CNT_W-1:0]      cycle_cnt;
    logic [1:0]            halt_cause;

    modport master (
        output start, halt_req, div_cfg,
        input  core_rst_n, ce, running, done, cycle_cnt, halt_cause
    );

    modport slave (
        input  start, halt_req, div_cfg,
        output core_rst_n, ce, running, done, cycle_cnt, halt_cause
    );
endinterface

// File: rtl/armleg_run_ctrl.sv
// rtl/armleg_run_ctrl.sv - ARMLEG run controller: reset sequencing, clock-enable dividers, cycle budget
//
// Purpose: holds the core in reset for RST_CYCLES after a start, then runs it with
// per-channel divided clock enables while counting cycles, and halts on request or
// when the cycle budget is reached.
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  asynchronous active-low reset
//   bus    slave side of armleg_run_ctrl_if (start/halt_req/div_cfg in, status out)
module armleg_run_ctrl #(
    parameter int CH         = 2,
    parameter int DIV_W      = 8,
    parameter int RST_CYCLES = 4,
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    armleg_run_ctrl_if.slave  bus
);
    localparam int HOLD_W = $clog2(RST_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_RUN,
        ST_HALT
    } state_t;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [CH*DIV_W-1:0] div_q, div_d;
    logic [CH*DIV_W-1:0] dcnt_q, dcnt_d;
    logic                core_rst_n_q, core_rst_n_d;
    logic [CH-1:0]       ce_q, ce_d;
    logic                running_q, running_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    cycle_cnt_q, cycle_cnt_d;
    logic [1:0]          halt_cause_q, halt_cause_d;

    logic [CNT_W-1:0]    cnt_inc;
    logic                budget_hit;
    logic [DIV_W-1:0]    dcnt_nxt;

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        div_d        = div_q;
        dcnt_d       = dcnt_q;
        core_rst_n_d = core_rst_n_q;
        ce_d         = '0;
        running_d    = running_q;
        done_d       = done_q;
        cycle_cnt_d  = cycle_cnt_q;
        halt_cause_d = halt_cause_q;
        dcnt_nxt     = '0;

        // Saturating increment; the budget compares against the count this edge produces.
        cnt_inc    = (&cycle_cnt_q) ? cycle_cnt_q : cycle_cnt_q + 1'b1;
        budget_hit = (MAX_CYCLES != 0) && (cnt_inc == CNT_W'(MAX_CYCLES));

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_HOLD;
                    hold_d  = HOLD_W'(RST_CYCLES);
                end
            end
            ST_HOLD: begin
                if (hold_q == HOLD_W'(1)) begin
                    // Enter RUN: RUN cycle 0 always carries a ce pulse on every channel.
                    state_d      = ST_RUN;
                    core_rst_n_d = 1'b1;
                    running_d    = 1'b1;
                    ce_d         = '1;
                    div_d        = bus.div_cfg;
                    dcnt_d       = '0;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            ST_RUN: begin
                cycle_cnt_d = cnt_inc;
                // dcnt holds k mod (d+1) for the current cycle; ce for the next cycle
                // is registered from the advanced count.
                for (int i = 0; i < CH; i++) begin
                    dcnt_nxt = (dcnt_q[i*DIV_W +: DIV_W] == div_q[i*DIV_W +: DIV_W])
                               ? '0 : dcnt_q[i*DIV_W +: DIV_W] + 1'b1;
                    dcnt_d[i*DIV_W +: DIV_W] = dcnt_nxt;
                    ce_d[i] = (dcnt_nxt == '0);
                end
                if (bus.halt_req || budget_hit) begin
                    state_d      = ST_HALT;
                    running_d    = 1'b0;
                    done_d       = 1'b1;
                    halt_cause_d = {budget_hit, bus.halt_req};
                    ce_d         = '0;
                end
            end
            ST_HALT: begin
                // core_rst_n stays high so the frozen core can be inspected.
                if (bus.start) begin
                    state_d      = ST_HOLD;
                    hold_d       = HOLD_W'(RST_CYCLES);
                    core_rst_n_d = 1'b0;
                    done_d       = 1'b0;
                    cycle_cnt_d  = '0;
                    halt_cause_d = 2'b00;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            div_q        <= '0;
            dcnt_q       <= '0;
            core_rst_n_q <= 1'b0;
            ce_q         <= '0;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            cycle_cnt_q  <= '0;
            halt_cause_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            div_q        <= div_d;
            dcnt_q       <= dcnt_d;
            core_rst_n_q <= core_rst_n_d;
            ce_q         <= ce_d;
            running_q    <= running_d;
            done_q       <= done_d;
            cycle_cnt_q  <= cycle_cnt_d;
            halt_cause_q <= halt_cause_d;
        end
    end

    assign bus.core_rst_n = core_rst_n_q;
    assign bus.ce         = ce_q;
    assign bus.running    = running_q;
    assign bus.done       = done_q;
    assign bus.cycle_cnt  = cycle_cnt_q;
    assign bus.halt_cause = halt_cause_q;
endmodule

// File: tb/tb_armleg_run_ctrl.sv
// tb/tb_armleg_run_ctrl.sv - self-checking bench for armleg_run_ctrl
module tb_armleg_run_ctrl;
    localparam int CH    = 2;
    localparam int DIV_W = 8;
    localparam int RST   = 4;
    localparam int CNT_W = 32;
    localparam int MAXC  = 10;
    localparam int VW    = CNT_W + CH + 5;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    armleg_run_ctrl_if #(.CH(CH), .DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();
    armleg_run_ctrl #(.CH(CH), .DIV_W(DIV_W), .RST_CYCLES(RST), .CNT_W(CNT_W), .MAX_CYCLES(MAXC))
        dut (.clk(clk), .reset(reset_n), .bus(bus));

    // Small-width instance: unlimited budget, narrow counter, max divide.
    armleg_run_ctrl_if #(.CH(1), .DIV_W(2), .CNT_W(3)) bus2 ();
    armleg_run_ctrl #(.CH(1), .DIV_W(2), .RST_CYCLES(1), .CNT_W(3), .MAX_CYCLES(0))
        dut2 (.clk(clk), .reset(reset_n), .bus(bus2));

    int total = 0;
    int bad = 0;

    // Reference model: mode 0 idle, 1 hold, 2 run, 3 halt; times are edge indices.
    int          cyc = 0;
    int          m_mode = 0;
    int          t_hold = 0;
    int          t_run = 0;
    int          m_cnt = 0;
    logic [1:0]  m_cause = 2'b00;
    int          m_d [CH];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode  = 0;
            m_cnt   = 0;
            m_cause = 2'b00;
        end else begin
            cyc = cyc + 1;
            case (m_mode)
                0: if (bus.start) begin m_mode = 1; t_hold = cyc; end
                1: if (cyc - t_hold == RST) begin
                       m_mode = 2;
                       t_run  = cyc;
                       for (int i = 0; i < CH; i++) m_d[i] = int'(bus.div_cfg[i*DIV_W +: DIV_W]);
                   end
                2: begin
                       int k;
                       k = cyc - t_run;
                       if (bus.halt_req || (MAXC != 0 && k == MAXC)) begin
                           m_mode  = 3;
                           m_cnt   = k;
                           m_cause = {(MAXC != 0 && k == MAXC), bus.halt_req};
                       end
                   end
                default: if (bus.start) begin
                       m_mode  = 1;
                       t_hold  = cyc;
                       m_cnt   = 0;
                       m_cause = 2'b00;
                   end
            endcase
        end
    end

    function automatic logic [VW-1:0] model_out();
        logic [CH-1:0]    e_ce;
        logic [CNT_W-1:0] e_cnt;
        int k;
        k = cyc - t_run;
        e_ce = '0;
        e_cnt = '0;
        for (int i = 0; i < CH; i++) e_ce[i] = (m_mode == 2) && (k % (m_d[i] + 1) == 0);
        if (m_mode == 2) e_cnt = CNT_W'(k);
        else if (m_mode == 3) e_cnt = CNT_W'(m_cnt);
        return {m_mode >= 2, m_mode == 2, m_mode == 3, (m_mode == 3) ? m_cause : 2'b00, e_ce, e_cnt};
    endfunction

    logic [VW-1:0] act;
    logic [VW-1:0] exp_v;
    assign act = {bus.core_rst_n, bus.running, bus.done, bus.halt_cause, bus.ce, bus.cycle_cnt};

    int n_low, ce0n, ce1n, n_run;

    task automatic test_reset();
        bus.start = 1'b0; bus.halt_req = 1'b0; bus.div_cfg = '0;
        bus2.start = 1'b0; bus2.halt_req = 1'b0; bus2.div_cfg = '0;
        reset_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (act !== '0) begin bad++; $display("FAIL reset_state act=%h exp=0", act); end
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        reset_n = 1'b1;
        bus.div_cfg = {8'd2, 8'd0};
        @(negedge clk);
        total++; exp_v = model_out();
        if (act !== exp_v) begin bad++; $display("FAIL latency_idle act=%h exp=%h", act, exp_v); end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        total++; exp_v = model_out();
        if (act !== exp_v) begin bad++; $display("FAIL latency_hold0 act=%h exp=%h", act, exp_v); end
        n_low = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++; exp_v = model_out();
            if (act !== exp_v) begin bad++; $display("FAIL latency_seq cyc=%0d act=%h exp=%h", cyc, act, exp_v); end
            if (bus.core_rst_n) break;
            n_low++;
        end
        total++;
        if (n_low != RST) begin bad++; $display("FAIL latency_hold_len act=%0d exp=%0d", n_low, RST); end
    endtask

    task automatic test_dividers();
        // Entered at RUN cycle 0.
        ce0n = int'(bus.ce[0]); ce1n = int'(bus.ce[1]);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            total++; exp_v = model_out();
            if (act !== exp_v) begin bad++; $display("FAIL div_seq k=%0d act=%h exp=%h", k, act, exp_v); end
            ce0n += int'(bus.ce[0]); ce1n += int'(bus.ce[1]);
            if (k == 8) bus.halt_req = 1'b1;
        end
        @(negedge clk);
        bus.halt_req = 1'b0;
        total++; exp_v = model_out();
        if (act !== exp_v) begin bad++; $display("FAIL div_halt act=%h exp=%h", act, exp_v); end
        total++;
        if (ce0n != 9 || ce1n != 3) begin bad++; $display("FAIL div_counts act=%0d/%0d exp=9/3", ce0n, ce1n); end
        total++;
        if (bus.cycle_cnt !== 32'd9 || bus.halt_cause !== 2'b01) begin
            bad++; $display("FAIL req_halt act=%0d/%b exp=9/01", bus.cycle_cnt, bus.halt_cause);
        end
    endtask

    task automatic test_budget();
        bus.start = 1'b1;
        n_run = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            total++; exp_v = model_out();
            if (act !== exp_v) begin bad++; $display("FAIL budget_seq cyc=%0d act=%h exp=%h", cyc, act, exp_v); end
            n_run += int'(bus.running);
            if (bus.done) break;
        end
        total++;
        if (bus.done !== 1'b1 || bus.cycle_cnt !== 32'd10 || bus.halt_cause !== 2'b10 || bus.ce !== 2'b00 || n_run != 10) begin
            bad++;
            $display("FAIL budget_end act=done%b cnt%0d cause%b ce%b run%0d exp=done1 cnt10 cause10 ce00 run10",
                     bus.done, bus.cycle_cnt, bus.halt_cause, bus.ce, n_run);
        end
    endtask

    task automatic test_both_causes();
        bus.start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            total++; exp_v = model_out();
            if (act !== exp_v) begin bad++; $display("FAIL both_seq cyc=%0d act=%h exp=%h", cyc, act, exp_v); end
            if (bus.running && bus.cycle_cnt == 32'd9) bus.halt_req = 1'b1;
            if (bus.done) break;
        end
        bus.halt_req = 1'b0;
        total++;
        if (bus.halt_cause !== 2'b11 || bus.cycle_cnt !== 32'd10) begin
            bad++; $display("FAIL both_cause act=%b/%0d exp=11/10", bus.halt_cause, bus.cycle_cnt);
        end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        total++;
        if (bus.done !== 1'b0 || bus.cycle_cnt !== '0 || bus.halt_cause !== 2'b00 || bus.core_rst_n !== 1'b0) begin
            bad++; $display("FAIL restart_clear act=%b/%0d/%b/%b exp=0/0/00/0",
                            bus.done, bus.cycle_cnt, bus.halt_cause, bus.core_rst_n);
        end
        n_low = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++; exp_v = model_out();
            if (act !== exp_v) begin bad++; $display("FAIL restart_seq cyc=%0d act=%h exp=%h", cyc, act, exp_v); end
            if (bus.core_rst_n) break;
            n_low++;
        end
        total++;
        if (n_low != RST) begin bad++; $display("FAIL restart_hold_len act=%0d exp=%0d", n_low, RST); end
    endtask

    task automatic test_reset_midrun();
        repeat (3) begin
            @(negedge clk);
            total++; exp_v = model_out();
            if (act !== exp_v) begin bad++; $display("FAIL midrun_pre act=%h exp=%h", act, exp_v); end
        end
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        total++;
        if (act !== '0) begin bad++; $display("FAIL async_reset act=%h exp=0", act); end
        bus.start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (act !== '0) begin bad++; $display("FAIL reset_hold act=%h exp=0", act); end
        end
        reset_n = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        total++; exp_v = model_out();
        if (act !== exp_v) begin bad++; $display("FAIL reset_release act=%h exp=%h", act, exp_v); end
    endtask

    task automatic test_div_change();
        bus.div_cfg = {8'd1, 8'd3};
        bus.start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            total++; exp_v = model_out();
            if (act !== exp_v) begin bad++; $display("FAIL divchg_seq cyc=%0d act=%h exp=%h", cyc, act, exp_v); end
            if (bus.done) break;
            if (bus.running) begin
                bus.div_cfg = 16'($urandom);
                bus.start = 1'($urandom_range(0, 1));
            end else begin
                bus.start = 1'b1;
            end
        end
        bus.start = 1'b0;
        total++;
        if (bus.done !== 1'b1) begin bad++; $display("FAIL divchg_end act=%b exp=1", bus.done); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.start = ($urandom_range(0, 5) == 0);
            bus.halt_req = ($urandom_range(0, 6) == 0);
            if ($urandom_range(0, 3) == 0)
                bus.div_cfg = {8'($urandom_range(0, 4)), ($urandom_range(0, 9) == 0) ? 8'hff : 8'($urandom_range(0, 3))};
            @(negedge clk);
            total++; exp_v = model_out();
            if (act !== exp_v) begin bad++; $display("FAIL random cyc=%0d act=%h exp=%h", cyc, act, exp_v); end
        end
        bus.start = 1'b0;
        bus.halt_req = 1'b0;
    endtask

    task automatic test_saturation();
        bus2.div_cfg = 2'd3;
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        total++;
        if (bus2.core_rst_n !== 1'b0 || bus2.running !== 1'b0) begin
            bad++; $display("FAIL sat_hold act=%b%b exp=00", bus2.core_rst_n, bus2.running);
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            total++;
            if (bus2.cycle_cnt !== 3'((k > 7) ? 7 : k) || bus2.ce !== 1'(k % 4 == 0) || bus2.running !== 1'b1) begin
                bad++; $display("FAIL sat_seq k=%0d act=cnt%0d ce%b run%b exp=cnt%0d ce%0d run1",
                                k, bus2.cycle_cnt, bus2.ce, bus2.running, (k > 7) ? 7 : k, (k % 4 == 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_dividers();
        test_budget();
        test_both_causes();
        test_reset_midrun();
        test_div_change();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
